ctrl_pipe: RTL
==============

# ctrl_pipe

Control-signal pipeline that sits directly downstream of the instruction decoder in the 5-stage RISC-V core. It captures the decoded control bits of the instruction in ID and carries them through ID/EX, EX/MEM and MEM/WB. It detects load-use hazards and inserts bubbles on stall or flush, and it drains an `ecall` halt to writeback before asserting `is_halted`.

## Interface
Parameters:
- `RW`, 5, register-index width.

Ports:
- `clk`  in  1  core clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears every pipeline register.
- `id_jal`, `id_jalr`, `id_branch`, `id_mem_read`, `id_mem_to_reg`, `id_mem_write`, `id_alu_src`, `id_reg_write`, `id_pc_to_reg`, `id_is_ecall`  in  1 each  decoded control of the instruction in ID.
- `id_rs1`, `id_rs2`, `id_rd`  in  RW  register indices of the ID instruction. `id_rs1` = 17 for `ecall`.
- `id_use_rs1`, `id_use_rs2`  in  1  instruction actually reads rs1/rs2.
- `id_halt_cond`  in  1  x17 == 10 for the ID instruction, already forwarded.
- `flush`  in  1  EX resolved a taken/mispredicted control transfer; kill the ID instruction.
- `stall`  out  1  hold PC and IF/ID this cycle.
- `ex_jal`, `ex_jalr`, `ex_branch`, `ex_alu_src`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`, `ex_reg_write`, `ex_pc_to_reg`  out  1 each  ID/EX register.
- `ex_rd`  out  RW  ID/EX register.
- `mem_mem_read`, `mem_mem_write`, `mem_mem_to_reg`, `mem_reg_write`, `mem_pc_to_reg`  out  1 each  EX/MEM register.
- `mem_rd`  out  RW  EX/MEM register.
- `wb_mem_to_reg`, `wb_reg_write`, `wb_pc_to_reg`  out  1 each  MEM/WB register.
- `wb_rd`  out  RW  MEM/WB register.
- `is_halted`  out  1  sticky halt, registered.

## Operation
- Each stage holds a valid bit, a halt bit, the control fields listed above and rd. A bubble has all bits zero.
- Load-use hazard: `hz = ex_mem_read & ex_rd != 0 & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd))`.
- Stall output: `stall = hz & ~flush & ~halt_pending`.
- `halt_pending` is an internal flag. It sets when a halt instruction is captured into ID/EX and clears only on `reset`.
- Capture into ID/EX each edge:
  - Load a bubble if `flush | hz | halt_pending`.
  - Otherwise load the ID fields, with valid = 1 and halt = `id_is_ecall & id_halt_cond`.
  - An `ecall` with `id_halt_cond` = 0 passes through as a no-op with all write and memory bits 0.
- EX/MEM <= ID/EX and MEM/WB <= EX/MEM every edge, unconditionally. Stall never freezes the back end.
- `is_halted` <= 1 on the edge after the MEM/WB halt bit is 1. It holds until `reset`.
- Older instructions ahead of the halt complete normally.
- Once `halt_pending` is set, every younger instruction becomes a bubble. No wrong-path register or memory write occurs.
- Priority at ID/EX capture: `reset` > `flush` > `halt_pending` > `hz` > normal.
- Flush while an `ecall` is in ID kills the halt: no halt bit, `halt_pending` stays 0.
- rd = 0 with `reg_write` = 1 is passed through unchanged; the register file ignores x0.

## Timing
- Reset: every output register is 0 on the first edge with `reset` = 1, including `is_halted` and `halt_pending`.
- `stall` is combinational. It is 0 during reset because `ex_mem_read` = 0.
- Latency: fields sampled at edge k appear on `ex_*` after k, on `mem_*` after k+1, on `wb_*` after k+2.
- Halt: `ecall` with halt condition in ID at edge k gives `is_halted` = 1 after edge k+3.
- A load-use stall lasts exactly one cycle. The bubble moves the load to EX/MEM, so `hz` drops the next cycle.
- `reset` mid-drain clears a halt in flight; `is_halted` stays 0.

## Test plan
- Reset: hold `reset` 2 cycles with random inputs -> all `ex_*`/`mem_*`/`wb_*`, `stall` and `is_halted` = 0.
- Plain flow: `addi x5` (reg_write=1, alu_src=1, rd=5) in ID at edge 0 -> `ex_rd`=5 after edge 0, `mem_rd`=5 after edge 1, `wb_reg_write`=1 and `wb_rd`=5 after edge 2.
- Load-use: `lw x6` in ID/EX, ID `add` with rs2=6 and use_rs2=1 -> `stall`=1 for one cycle, one bubble in ID/EX, `add` captured on the following edge. Repeat with rs2=0 and rd=0 -> `stall`=0.
- Flush vs stall: hazard and `flush` both 1 -> `stall`=0, bubble captured, `ex_reg_write`=0.
- Halt: `ecall` with halt_cond=1 at edge k followed by `sw` -> `mem_mem_write` never 1 for the `sw`, `is_halted`=1 after edge k+3. Non-halt `ecall` (halt_cond=0) -> `is_halted` stays 0.
- Halt killed: `ecall` with halt_cond=1 and `flush`=1 -> no halt; `reset` asserted at k+2 during another halt drain -> `is_halted` stays 0.

Source files
------------

// File: rtl/ctrl_pipe_if.sv
// Handshake bundle between the decoder and the control-signal pipeline.
// The master drives the ID-stage fields; the slave returns stage outputs.
interface ctrl_pipe_if #(
    parameter int RW = 5
);
    logic          id_jal;
    logic          id_jalr;
    logic          id_branch;
    logic          id_mem_read;
    logic          id_mem_to_reg;
    logic          id_mem_write;
    logic          id_alu_src;
    logic          id_reg_write;
    logic          id_pc_to_reg;
    logic          id_is_ecall;
    logic [RW-1:0] id_rs1;
    logic [RW-1:0] id_rs2;
    logic [RW-1:0] id_rd;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic          id_halt_cond;
    logic          flush;

    logic          stall;
    logic          ex_jal;
    logic          ex_jalr;
    logic          ex_branch;
    logic          ex_alu_src;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_mem_to_reg;
    logic          ex_reg_write;
    logic          ex_pc_to_reg;
    logic [RW-1:0] ex_rd;
    logic          mem_mem_read;
    logic          mem_mem_write;
    logic          mem_mem_to_reg;
    logic          mem_reg_write;
    logic          mem_pc_to_reg;
    logic [RW-1:0] mem_rd;
    logic          wb_mem_to_reg;
    logic          wb_reg_write;
    logic          wb_pc_to_reg;
    logic [RW-1:0] wb_rd;
    logic          is_halted;

    modport master (
        output id_jal, id_jalr, id_branch, id_mem_read, id_mem_to_reg, id_mem_write,
               id_alu_src, id_reg_write, id_pc_to_reg, id_is_ecall,
               id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_halt_cond, flush,
        input  stall,
               ex_jal, ex_jalr, ex_branch, ex_alu_src, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_reg_write, ex_pc_to_reg, ex_rd,
               mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write, mem_pc_to_reg, mem_rd,
               wb_mem_to_reg, wb_reg_write, wb_pc_to_reg, wb_rd, is_halted
    );

    modport slave (
        input  id_jal, id_jalr, id_branch, id_mem_read, id_mem_to_reg, id_mem_write,
               id_alu_src, id_reg_write, id_pc_to_reg, id_is_ecall,
               id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_halt_cond, flush,
        output stall,
               ex_jal, ex_jalr, ex_branch, ex_alu_src, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_reg_write, ex_pc_to_reg, ex_rd,
               mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write, mem_pc_to_reg, mem_rd,
               wb_mem_to_reg, wb_reg_write, wb_pc_to_reg, wb_rd, is_halted
    );
endinterface

// File: rtl/ctrl_pipe.sv
// Carries decoded control bits through ID/EX, EX/MEM and MEM/WB, inserts
// load-use / flush bubbles and drains an ecall halt to writeback.
module ctrl_pipe #(
    parameter int RW = 5
) (
    input  logic       clk,
    input  logic       reset,
    ctrl_pipe_if.slave bus
);

    typedef struct packed {
        logic          valid;
        logic          halt;
        logic          jal;
        logic          jalr;
        logic          branch;
        logic          alu_src;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
        logic          reg_write;
        logic          pc_to_reg;
        logic [RW-1:0] rd;
    } idex_t;

    typedef struct packed {
        logic          valid;
        logic          halt;
        logic          mem_read;
        logic          mem_write;
        logic          mem_to_reg;
        logic          reg_write;
        logic          pc_to_reg;
        logic [RW-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic          valid;
        logic          halt;
        logic          mem_to_reg;
        logic          reg_write;
        logic          pc_to_reg;
        logic [RW-1:0] rd;
    } memwb_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } halt_state_e;

    idex_t       idex_q, idex_d;
    exmem_t      exmem_q, exmem_d;
    memwb_t      memwb_q, memwb_d;
    halt_state_e state_q, state_d;

    logic halt_pending;
    logic rs1_hit;
    logic rs2_hit;
    logic hz;

    always_comb begin
        rs1_hit = bus.id_use_rs1 && (bus.id_rs1 == idex_q.rd);
        rs2_hit = bus.id_use_rs2 && (bus.id_rs2 == idex_q.rd);
        hz      = idex_q.mem_read && (idex_q.rd != '0) && (rs1_hit || rs2_hit);
    end

    // Once a halt is in flight, halt_pending stays up until reset, even after is_halted.
    assign halt_pending = (state_q != ST_RUN);
    assign bus.stall    = hz && !bus.flush && !halt_pending;

    // An ecall never writes or touches memory; only its halt bit matters.
    always_comb begin
        idex_d = '0;
        if (!(bus.flush || halt_pending || hz)) begin
            idex_d.valid = 1'b1;
            idex_d.rd    = bus.id_rd;
            if (bus.id_is_ecall) begin
                idex_d.halt = bus.id_halt_cond;
            end else begin
                idex_d.jal        = bus.id_jal;
                idex_d.jalr       = bus.id_jalr;
                idex_d.branch     = bus.id_branch;
                idex_d.alu_src    = bus.id_alu_src;
                idex_d.mem_read   = bus.id_mem_read;
                idex_d.mem_write  = bus.id_mem_write;
                idex_d.mem_to_reg = bus.id_mem_to_reg;
                idex_d.reg_write  = bus.id_reg_write;
                idex_d.pc_to_reg  = bus.id_pc_to_reg;
            end
        end
    end

    always_comb begin
        exmem_d            = '0;
        exmem_d.valid      = idex_q.valid;
        exmem_d.halt       = idex_q.halt;
        exmem_d.mem_read   = idex_q.mem_read;
        exmem_d.mem_write  = idex_q.mem_write;
        exmem_d.mem_to_reg = idex_q.mem_to_reg;
        exmem_d.reg_write  = idex_q.reg_write;
        exmem_d.pc_to_reg  = idex_q.pc_to_reg;
        exmem_d.rd         = idex_q.rd;

        memwb_d            = '0;
        memwb_d.valid      = exmem_q.valid;
        memwb_d.halt       = exmem_q.halt;
        memwb_d.mem_to_reg = exmem_q.mem_to_reg;
        memwb_d.reg_write  = exmem_q.reg_write;
        memwb_d.pc_to_reg  = exmem_q.pc_to_reg;
        memwb_d.rd         = exmem_q.rd;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (idex_d.halt) state_d = ST_DRAIN;
            ST_DRAIN:  if (memwb_q.valid && memwb_q.halt) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            state_q <= ST_RUN;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            state_q <= state_d;
        end
    end

    assign bus.ex_jal         = idex_q.jal;
    assign bus.ex_jalr        = idex_q.jalr;
    assign bus.ex_branch      = idex_q.branch;
    assign bus.ex_alu_src     = idex_q.alu_src;
    assign bus.ex_mem_read    = idex_q.mem_read;
    assign bus.ex_mem_write   = idex_q.mem_write;
    assign bus.ex_mem_to_reg  = idex_q.mem_to_reg;
    assign bus.ex_reg_write   = idex_q.reg_write;
    assign bus.ex_pc_to_reg   = idex_q.pc_to_reg;
    assign bus.ex_rd          = idex_q.rd;

    assign bus.mem_mem_read   = exmem_q.mem_read;
    assign bus.mem_mem_write  = exmem_q.mem_write;
    assign bus.mem_mem_to_reg = exmem_q.mem_to_reg;
    assign bus.mem_reg_write  = exmem_q.reg_write;
    assign bus.mem_pc_to_reg  = exmem_q.pc_to_reg;
    assign bus.mem_rd         = exmem_q.rd;

    assign bus.wb_mem_to_reg  = memwb_q.mem_to_reg;
    assign bus.wb_reg_write   = memwb_q.reg_write;
    assign bus.wb_pc_to_reg   = memwb_q.pc_to_reg;
    assign bus.wb_rd          = memwb_q.rd;

    assign bus.is_halted      = (state_q == ST_HALTED);

endmodule
